pc_flag_ctrl: RTL
=================

PC_FLAG_CTRL -- requirements
Module: pc_flag_ctrl

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 flag_in  input  3  ALU FLAG output; bit0=N, bit1=V, bit2=Z.
REQ-005 flag_we  input  1  write enable for the flag register.
REQ-006 branch  input  1  conditional branch to PC-relative target (B).
REQ-007 branch_reg  input  1  conditional branch to register target (BR).
REQ-008 ccc  input  3  branch condition code.
REQ-009 imm9  input  9  signed word offset for B.
REQ-010 reg_target  input  16  byte address for BR.
REQ-011 halt  input  1  halt request from decode.
REQ-012 pc_out  output  16  current PC (instruction fetch address).
REQ-013 pc_plus2  output  16  pc_out + 2, modulo 2^16.
REQ-014 flag_out  output  3  registered flags, same bit order; drives ALU FLAG_in.
REQ-015 taken  output  1  combinational: a branch is taken this cycle.
REQ-016 halted  output  1  high while in HALT state.

Function
REQ-017 The block SHALL hold a 2-state FSM: RUN, HALT.
REQ-018 In RUN with halt=0, next PC SHALL be: target if taken, else pc_plus2.
REQ-019 B target SHALL be pc_plus2 + (sign_extend(imm9) << 1), modulo 2^16.
REQ-020 BR target SHALL be reg_target, bit0 forced to 0.
REQ-021 If branch and branch_reg are both 1, branch_reg SHALL take priority.
REQ-022 Conditions SHALL evaluate flag_out (pre-update flags), never flag_in: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|N=0; 101 N=1|Z=1; 110 V=1; 111 always.
REQ-023 taken SHALL be (branch|branch_reg) & condition & state==RUN & halt==0.
REQ-024 In RUN with flag_we=1 and halt=0, flag register SHALL load flag_in at the edge.
REQ-025 In RUN with halt=1, FSM SHALL go to HALT; PC SHALL hold (no increment, no branch); flag write SHALL be suppressed.
REQ-026 In HALT, PC, flags and state SHALL hold regardless of all inputs except rst; halted=1.
REQ-027 Wrap-around: pc 16'hFFFE with no branch SHALL advance to 16'h0000.
REQ-028 A branch with flag_we in the same cycle SHALL use old flags for the decision and still load the new flags.

Reset
REQ-029 On rst=1, immediately and asynchronously: pc_out=RESET_PC, flag_out=3'b000, state=RUN, halted=0.
REQ-030 Reset asserted mid-operation or in HALT SHALL abort to the reset state; first fetch after release is RESET_PC.
REQ-031 While rst=1, taken SHALL be 0.

Structure
REQ-032 Shared package SHALL hold flag bit indices (N=0,V=1,Z=2), the eight ccc encodings, and the RUN/HALT state encoding.
REQ-033 Condition evaluation SHALL be one combinational sub-module, cond_eval (inputs ccc, flags; output cond).
REQ-034 PC adder and target adder SHALL be separate 16-bit adders; no shared carry-chain with the ALU.

Verification
REQ-035 Reset then 4 idle cycles -> pc_out 0000,0002,0004,0006,0008; flag_out 000.
REQ-036 flags=Z(100), pc=0010, branch ccc=001 imm9=9'h003 -> taken=1, next pc 0018; same with ccc=000 -> pc 0012.
REQ-037 pc=0020, branch imm9=9'h1FF ccc=111 -> next pc 0020; branch_reg reg_target=1235 same cycle -> next pc 1234.
REQ-038 flags=000, flag_we=1 flag_in=001 with branch ccc=011 -> not taken, flag_out=001 after edge; next-cycle ccc=011 branch -> taken.
REQ-039 halt at pc=0030 with flag_we=1 flag_in=111 -> pc holds 0030, flag_out unchanged, halted=1 for 10 cycles despite branch inputs.
REQ-040 pc=FFFE idle -> 0000; rst pulse mid-cycle while HALT -> pc_out=RESET_PC asynchronously, halted=0.

Source files
------------

// File: rtl/pc_flag_ctrl_pkg.sv
// pc_flag_ctrl_pkg
// Shared constants for the PC / flag controller:
//   - bit positions of the N, V and Z flags inside the 3-bit flag word
//   - the eight branch condition-code encodings (ccc)
//   - the RUN/HALT state encoding of the controller FSM
//   - a helper that turns the signed 9-bit word offset into a byte offset
package pc_flag_ctrl_pkg;

   // Flag word layout, shared by ALU FLAG output and flag register.
   localparam int FLAG_N = 0;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 2;

   // Branch condition codes.
   localparam logic [2:0] CCC_ZC     = 3'b000; // Z == 0
   localparam logic [2:0] CCC_ZS     = 3'b001; // Z == 1
   localparam logic [2:0] CCC_GT     = 3'b010; // Z == 0 and N == 0
   localparam logic [2:0] CCC_LT     = 3'b011; // N == 1
   localparam logic [2:0] CCC_GE     = 3'b100; // Z == 1 or N == 0
   localparam logic [2:0] CCC_LE     = 3'b101; // N == 1 or Z == 1
   localparam logic [2:0] CCC_OVF    = 3'b110; // V == 1
   localparam logic [2:0] CCC_ALWAYS = 3'b111; // unconditional

   // Controller FSM encoding.
   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   // Signed word offset -> byte offset: sign-extend to 15 bits, shift left 1.
   function automatic logic [15:0] word_off_to_bytes(input logic [8:0] imm9);
      return {{6{imm9[8]}}, imm9, 1'b0};
   endfunction

endpackage

// File: rtl/pc_flag_ctrl_cond.sv
// cond_eval
// Purely combinational branch condition evaluator.
// Ports:
//   ccc   in  3  condition code
//   flags in  3  flag word (bit0=N, bit1=V, bit2=Z)
//   cond  out 1  condition holds for the given flags
module cond_eval
   import pc_flag_ctrl_pkg::*;
(
   input  logic [2:0] ccc,
   input  logic [2:0] flags,
   output logic       cond
);

   logic n_f;
   logic v_f;
   logic z_f;

   assign n_f = flags[FLAG_N];
   assign v_f = flags[FLAG_V];
   assign z_f = flags[FLAG_Z];

   always_comb begin
      cond = 1'b0;
      unique case (ccc)
         CCC_ZC:     cond = ~z_f;
         CCC_ZS:     cond = z_f;
         CCC_GT:     cond = ~z_f & ~n_f;
         CCC_LT:     cond = n_f;
         CCC_GE:     cond = z_f | ~n_f;
         CCC_LE:     cond = n_f | z_f;
         CCC_OVF:    cond = v_f;
         CCC_ALWAYS: cond = 1'b1;
         default:    cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_flag_ctrl.sv
// pc_flag_ctrl
// Program counter, flag register and RUN/HALT control for a small 16-bit core.
// Ports:
//   clk        in  1   system clock, rising edge
//   rst        in  1   asynchronous active-high reset
//   flag_in    in  3   ALU flags (bit0=N, bit1=V, bit2=Z)
//   flag_we    in  1   load flag_in into the flag register
//   branch     in  1   conditional PC-relative branch (B)
//   branch_reg in  1   conditional register branch (BR), wins over B
//   ccc        in  3   branch condition code
//   imm9       in  9   signed word offset for B
//   reg_target in  16  byte target for BR (bit0 ignored)
//   halt       in  1   halt request
//   pc_out     out 16  current fetch address
//   pc_plus2   out 16  pc_out + 2
//   flag_out   out 3   registered flags
//   taken      out 1   a branch is taken this cycle
//   halted     out 1   FSM is in HALT (this is the full FSM state view)
//
// Handshake: none; every input is sampled as a level on each rising edge,
// and taken is a same-cycle combinational view of the branch decision.
module pc_flag_ctrl
   import pc_flag_ctrl_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  flag_in,
   input  logic        flag_we,
   input  logic        branch,
   input  logic        branch_reg,
   input  logic [2:0]  ccc,
   input  logic [8:0]  imm9,
   input  logic [15:0] reg_target,
   input  logic        halt,
   output logic [15:0] pc_out,
   output logic [15:0] pc_plus2,
   output logic [2:0]  flag_out,
   output logic        taken,
   output logic        halted
);

   logic [0:0]  state_q, state_d;
   logic [15:0] pc_q,    pc_d;
   logic [2:0]  flag_q,  flag_d;

   logic [15:0] seq_pc;
   logic [15:0] b_target;
   logic [15:0] br_target;
   logic        cond;
   logic        advance;

   // Sequential address and PC-relative target use their own adders.
   assign seq_pc    = pc_q + 16'd2;
   assign b_target  = seq_pc + word_off_to_bytes(imm9);
   assign br_target = {reg_target[15:1], 1'b0};

   // Decision always looks at the registered flags, so a same-cycle flag
   // write cannot influence the branch it accompanies.
   cond_eval u_cond (
      .ccc   (ccc),
      .flags (flag_q),
      .cond  (cond)
   );

   // The PC and flags only move in RUN without a halt request. rst is
   // included so taken stays low for the whole reset pulse.
   assign advance = (state_q == ST_RUN) & ~halt & ~rst;
   assign taken   = (branch | branch_reg) & cond & advance;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flag_d  = flag_q;
      if (state_q == ST_RUN) begin
         if (halt) begin
            state_d = ST_HALT;
         end else begin
            if (taken) begin
               pc_d = branch_reg ? br_target : b_target;
            end else begin
               pc_d = seq_pc;
            end
            if (flag_we) begin
               flag_d = flag_in;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         flag_q  <= 3'b000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flag_q  <= flag_d;
      end
   end

   assign pc_out   = pc_q;
   assign pc_plus2 = seq_pc;
   assign flag_out = flag_q;
   assign halted   = (state_q == ST_HALT);

endmodule
